// File: rtl/cic_comb_seq.sv
// Sequencer for a small-footprint CIC comb chain: decimates integrator strobes
// and steps the shared comb stages through one latch/push sequence per decimated sample.
`timescale 1ns/1ps
module cic_comb_seq #(
    parameter int CIC_R     = 4,
    parameter int CIC_N     = 3,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 int_str,
    output logic                 dec_str,
    output logic                 out_latch_str,
    output logic                 summ_rdy_str,
    output logic                 busy,
    output logic                 overrun,
    output logic [CNT_WIDTH-1:0] dec_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOAD = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] R_LAST = CNT_WIDTH'(CIC_R - 1);
    localparam logic [CNT_WIDTH-1:0] N_LAST = CNT_WIDTH'(CIC_N - 1);

    state_t                 state_reg, state_next;
    logic [CNT_WIDTH-1:0]   phase_reg, phase_next;
    logic [CNT_WIDTH-1:0]   dec_cnt_reg, dec_cnt_next;
    logic                   overrun_reg, overrun_next;
    logic                   dec_wrap;
    logic                   start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            phase_reg   <= '0;
            dec_cnt_reg <= '0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            phase_reg   <= phase_next;
            dec_cnt_reg <= dec_cnt_next;
            overrun_reg <= overrun_next;
        end
    end

    always_comb begin
        dec_wrap     = (dec_cnt_reg == R_LAST);
        start        = int_str && dec_wrap;
        dec_cnt_next = dec_cnt_reg;
        state_next   = state_reg;
        phase_next   = phase_reg;
        overrun_next = overrun_reg;

        if (int_str) begin
            dec_cnt_next = dec_wrap ? '0 : dec_cnt_reg + 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    phase_next = '0;
                end
            end
            RUN: begin
                // The chain is still busy with the previous sample: drop it.
                if (start) begin
                    overrun_next = 1'b1;
                end
                phase_next = phase_reg + 1'b1;
                if (phase_reg == N_LAST) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                phase_next = '0;
                state_next = start ? RUN : IDLE;
            end
            default: begin
                state_next = IDLE;
                phase_next = '0;
            end
        endcase

        if (clear) begin
            dec_cnt_next = '0;
            state_next   = IDLE;
            phase_next   = '0;
            overrun_next = 1'b0;
        end
    end

    // Strobes decode straight from registered state, so they are glitch-free
    // and drop to zero the moment reset is applied.
    assign dec_str       = (state_reg == RUN) && (phase_reg == '0);
    assign out_latch_str = (state_reg == RUN) && (phase_reg == N_LAST);
    assign summ_rdy_str  = (state_reg == LOAD);
    assign busy          = (state_reg != IDLE);
    assign overrun       = overrun_reg;
    assign dec_cnt       = dec_cnt_reg;

endmodule

// File: tb/tb_cic_comb_seq.sv
// Bench for cic_comb_seq: three parameterisations share one stimulus stream and
// are checked against a timeline model plus fixed vector tables.
`timescale 1ns/1ps
module tb_cic_comb_seq;

    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clear = 1'b0;
    logic int_str = 1'b0;

    logic [NDUT-1:0] dec_s, lat_s, sum_s, bsy_s, ovr_s;
    logic [15:0]     cnt_s [NDUT];

    always #5 clk = ~clk;

    cic_comb_seq #(.CIC_R(4), .CIC_N(3), .CNT_WIDTH(16)) u_r4n3 (
        .clk(clk), .reset(reset), .clear(clear), .int_str(int_str),
        .dec_str(dec_s[0]), .out_latch_str(lat_s[0]), .summ_rdy_str(sum_s[0]),
        .busy(bsy_s[0]), .overrun(ovr_s[0]), .dec_cnt(cnt_s[0]));

    cic_comb_seq #(.CIC_R(3), .CIC_N(3), .CNT_WIDTH(16)) u_r3n3 (
        .clk(clk), .reset(reset), .clear(clear), .int_str(int_str),
        .dec_str(dec_s[1]), .out_latch_str(lat_s[1]), .summ_rdy_str(sum_s[1]),
        .busy(bsy_s[1]), .overrun(ovr_s[1]), .dec_cnt(cnt_s[1]));

    cic_comb_seq #(.CIC_R(1), .CIC_N(1), .CNT_WIDTH(16)) u_r1n1 (
        .clk(clk), .reset(reset), .clear(clear), .int_str(int_str),
        .dec_str(dec_s[2]), .out_latch_str(lat_s[2]), .summ_rdy_str(sum_s[2]),
        .busy(bsy_s[2]), .overrun(ovr_s[2]), .dec_cnt(cnt_s[2]));

    // Reference model: a sequence is the cycle its dec_str fires; every strobe
    // is an offset from that cycle.
    int r_of [NDUT] = '{4, 3, 1};
    int n_of [NDUT] = '{3, 3, 1};
    int m_cnt [NDUT];
    int m_start [NDUT];
    bit m_ovr [NDUT];
    int cyc;
    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        bit         ist;
        bit         clr;
        logic [4:0] e0;
        logic [4:0] e1;
        logic [4:0] e2;
        int         c0;
        int         c1;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string name, input int dut, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s dut%0d cyc=%0d: got %0h expected %0h", name, dut, cyc, act, exp);
    endtask

    function automatic logic [4:0] obs(input int i);
        return {dec_s[i], lat_s[i], sum_s[i], bsy_s[i], ovr_s[i]};
    endfunction

    function automatic logic [4:0] model_exp(input int i);
        int k;
        k = cyc - m_start[i];
        return {k == 0, k == n_of[i] - 1, k == n_of[i], (k >= 0) && (k <= n_of[i]), m_ovr[i]};
    endfunction

    task automatic model_reset();
        cyc = 0;
        for (int i = 0; i < NDUT; i++) begin
            m_cnt[i]   = 0;
            m_start[i] = -1000;
            m_ovr[i]   = 1'b0;
        end
    endtask

    task automatic sample_check();
        for (int i = 0; i < NDUT; i++) begin
            chk("model_flags", i, obs(i), model_exp(i));
            chk("model_cnt", i, cnt_s[i], m_cnt[i]);
        end
    endtask

    task automatic drive(input bit ist, input bit clr);
        int k;
        int_str = ist;
        clear   = clr;
        for (int i = 0; i < NDUT; i++) begin
            if (clr) begin
                m_cnt[i]   = 0;
                m_ovr[i]   = 1'b0;
                m_start[i] = -1000;
            end else if (ist) begin
                if (m_cnt[i] == r_of[i] - 1) begin
                    m_cnt[i] = 0;
                    k = cyc - m_start[i];
                    if (k < 0 || k >= n_of[i]) m_start[i] = cyc + 1;
                    else m_ovr[i] = 1'b1;
                end else begin
                    m_cnt[i]++;
                end
            end
        end
        cyc++;
    endtask

    task automatic step(input bit ist, input bit clr);
        @(negedge clk);
        sample_check();
        drive(ist, clr);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        int_str = 1'b0;
        clear   = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            chk("reset_flags", i, obs(i), 0);
            chk("reset_cnt", i, cnt_s[i], 0);
        end
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        // Continuous int_str; flags are {dec_str, out_latch_str, summ_rdy_str, busy, overrun}.
        logic [4:0] e0tab [10] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b10010,
                                   5'b00010, 5'b01010, 5'b00110, 5'b10010, 5'b00010};
        logic [4:0] e1tab [10] = '{5'b00000, 5'b00000, 5'b00000, 5'b10010, 5'b00010,
                                   5'b01010, 5'b00111, 5'b00001, 5'b00001, 5'b10011};
        logic [4:0] e2tab [10] = '{5'b00000, 5'b11010, 5'b00111, 5'b11011, 5'b00111,
                                   5'b11011, 5'b00111, 5'b11011, 5'b00111, 5'b11011};
        int first;
        for (int r = 0; r < 10; r++) begin
            vt[r] = '{1'b1, 1'b0, e0tab[r], e1tab[r], e2tab[r], r % 4, r % 3};
        end

        model_reset();
        do_reset();

        for (int r = 0; r < 10; r++) begin
            @(negedge clk);
            sample_check();
            chk("tbl_flags", 0, obs(0), vt[r].e0);
            chk("tbl_cnt", 0, cnt_s[0], vt[r].c0);
            chk("tbl_flags", 1, obs(1), vt[r].e1);
            chk("tbl_cnt", 1, cnt_s[1], vt[r].c1);
            chk("tbl_flags", 2, obs(2), vt[r].e2);
            chk("tbl_cnt", 2, cnt_s[2], 0);
            drive(vt[r].ist, vt[r].clr);
        end

        // Sparse input: strobes every tenth cycle.
        do_reset();
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            sample_check();
            if (c == 1 || c == 11 || c == 21) chk("sparse_cnt", 0, cnt_s[0], c / 10 + 1);
            if (c == 31) chk("sparse_dec", 0, dec_s[0], 1);
            if (c == 33) chk("sparse_latch", 0, lat_s[0], 1);
            if (c == 34) chk("sparse_summ", 0, sum_s[0], 1);
            drive(c % 10 == 0, 1'b0);
        end

        // Clear at phase 1 of a sequence, with int_str also high.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            sample_check();
            if (c == 4) chk("clr_dec", 0, dec_s[0], 1);
            if (c == 5) chk("clr_ovr_before", 2, ovr_s[2], 1);
            if (c >= 5) chk("clr_no_strobe", 0, {lat_s[0], sum_s[0]}, 0);
            if (c == 6) begin
                chk("clr_busy", 0, bsy_s[0], 0);
                chk("clr_cnt", 0, cnt_s[0], 0);
                chk("clr_ovr_after", 2, ovr_s[2], 0);
            end
            drive(c <= 5, c == 5);
        end

        // Asynchronous reset pulse between edges while running.
        do_reset();
        for (int c = 0; c < 5; c++) step(1'b1, 1'b0);
        @(negedge clk);
        sample_check();
        chk("arst_running", 0, bsy_s[0], 1);
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            chk("arst_flags", i, obs(i), 0);
            chk("arst_cnt", i, cnt_s[i], 0);
        end
        #1 reset = 1'b0;
        model_reset();
        drive(1'b1, 1'b0);
        first = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            sample_check();
            if (dec_s[0] && first < 0) first = k;
            drive(1'b1, 1'b0);
        end
        chk("arst_resume", 0, first, 4);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
